// File: rtl/iod_dly_seq.sv
// iod_dly_seq: turns load / move-N requests into spaced IOD delay-line pulses and tracks the tap position.
// Define IOD_DLY_SW_CLAMP_EN to stop a move before any pulse that would leave [0, MAX_TAPS].
module iod_dly_seq #(
    parameter int TAP_W       = 8,
    parameter int TAP_INIT    = 1,
    parameter int MAX_TAPS    = 255,
    parameter int MOVE_GAP    = 3,
    parameter int LOAD_CYCLES = 2
) (
    input  logic             FAB_CLK,
    input  logic             ARST_N,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_op,
    input  logic             req_dir,
    input  logic [TAP_W-1:0] req_taps,
    output logic             done,
    output logic             done_err,
    output logic [TAP_W-1:0] tap_count,
    output logic             DELAY_LINE_MOVE,
    output logic             DELAY_LINE_DIRECTION,
    output logic             DELAY_LINE_LOAD,
    input  logic             DELAY_LINE_OUT_OF_RANGE
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETUP,
        ST_PULSE,
        ST_GAP,
        ST_DONE
    } state_e;

`ifdef IOD_DLY_SW_CLAMP_EN
    localparam logic CLAMP_EN = 1'b1;
`else
    localparam logic CLAMP_EN = 1'b0;
`endif

    localparam logic [3:0]       GAP_LAST  = 4'(MOVE_GAP - 1);
    localparam logic [3:0]       LOAD_LAST = 4'(LOAD_CYCLES - 1);
    localparam logic [TAP_W-1:0] TAP_RST   = TAP_W'(TAP_INIT);

    // True when one more pulse in direction 'up' would leave the software window.
    function automatic logic clamp_hit(input logic [TAP_W-1:0] tap, input logic up);
        if (!CLAMP_EN) begin
            return 1'b0;
        end
        return up ? (int'(tap) >= MAX_TAPS) : (tap == '0);
    endfunction

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [TAP_W-1:0]   rem_q, rem_d;
    logic [TAP_W-1:0]   tap_q, tap_d;
    logic               dir_q, dir_d;
    logic               err_q, err_d;
    logic               move_q, move_d;
    logic               load_q, load_d;
    logic               done_q, done_d;
    logic               ready_q, ready_d;
    logic               oor_s1_q, oor_s1_d;
    logic               oor_s2_q, oor_s2_d;
    logic [TAP_W-1:0]   tap_step;

    assign tap_step = dir_q ? tap_q + TAP_W'(1) : tap_q - TAP_W'(1);

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        tap_d    = tap_q;
        dir_d    = dir_q;
        err_d    = 1'b0;
        oor_s1_d = DELAY_LINE_OUT_OF_RANGE;
        oor_s2_d = oor_s1_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_op) begin
                        state_d = ST_LOAD;
                        cnt_d   = LOAD_LAST;
                    end else begin
                        state_d = ST_SETUP;
                        dir_d   = req_dir;
                        rem_d   = req_taps;
                    end
                end
            end
            ST_LOAD: begin
                if (cnt_q == '0) begin
                    tap_d   = TAP_RST;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_SETUP: begin
                if (rem_q == '0) begin
                    state_d = ST_DONE;
                end else if (clamp_hit(tap_q, dir_q)) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_PULSE;
                end
            end
            ST_PULSE: begin
                rem_d   = rem_q - TAP_W'(1);
                cnt_d   = GAP_LAST;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (oor_s2_q) begin
                    // The IOD refused this pulse: keep the old tap and abandon the rest.
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    tap_d = tap_step;
                    if (rem_q == '0) begin
                        state_d = ST_DONE;
                    end else if (clamp_hit(tap_step, dir_q)) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_PULSE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs decode the next state so that they are registered yet aligned with it.
        move_d  = (state_d == ST_PULSE);
        load_d  = (state_d == ST_LOAD);
        done_d  = (state_d == ST_DONE);
        ready_d = (state_d == ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            tap_q    <= TAP_RST;
            dir_q    <= 1'b0;
            err_q    <= 1'b0;
            move_q   <= 1'b0;
            load_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
            oor_s1_q <= 1'b0;
            oor_s2_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            tap_q    <= tap_d;
            dir_q    <= dir_d;
            err_q    <= err_d;
            move_q   <= move_d;
            load_q   <= load_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
            oor_s1_q <= oor_s1_d;
            oor_s2_q <= oor_s2_d;
        end
    end

    assign req_ready            = ready_q;
    assign done                 = done_q;
    assign done_err             = err_q;
    assign tap_count            = tap_q;
    assign DELAY_LINE_MOVE      = move_q;
    assign DELAY_LINE_DIRECTION = dir_q;
    assign DELAY_LINE_LOAD      = load_q;

endmodule

// File: tb/tb_iod_dly_seq.sv
// Self-checking bench for iod_dly_seq: request-level timeline model checked every cycle,
// plus directed literal checks; honours IOD_DLY_SW_CLAMP_EN (MAX_TAPS = 3 when defined).
module tb_iod_dly_seq;

    localparam int TAP_W       = 8;
    localparam int TAP_INIT    = 1;
    localparam int MOVE_GAP    = 3;
    localparam int LOAD_CYCLES = 2;
`ifdef IOD_DLY_SW_CLAMP_EN
    localparam int MAX_T = 3;
`else
    localparam int MAX_T = 255;
`endif
    localparam int PER = MOVE_GAP + 1;

    logic             FAB_CLK = 1'b0;
    logic             ARST_N = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_op = 1'b0;
    logic             req_dir = 1'b0;
    logic [TAP_W-1:0] req_taps = '0;
    logic             oor = 1'b0;
    logic             req_ready, done, done_err, mv, dirn, ld;
    logic [TAP_W-1:0] tap_count;

    iod_dly_seq #(
        .TAP_W(TAP_W), .TAP_INIT(TAP_INIT), .MAX_TAPS(MAX_T),
        .MOVE_GAP(MOVE_GAP), .LOAD_CYCLES(LOAD_CYCLES)
    ) dut (
        .FAB_CLK(FAB_CLK), .ARST_N(ARST_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_dir(req_dir), .req_taps(req_taps),
        .done(done), .done_err(done_err), .tap_count(tap_count),
        .DELAY_LINE_MOVE(mv), .DELAY_LINE_DIRECTION(dirn),
        .DELAY_LINE_LOAD(ld), .DELAY_LINE_OUT_OF_RANGE(oor)
    );

    initial forever #5 FAB_CLK = ~FAB_CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit in_rst = 1'b1;
    int req_fail = 0;

    // Model of the request in flight, expressed as a timeline relative to acceptance.
    bit               busy = 1'b0;
    int               acc_cyc = 0, acc_cnt = 0, d_off = 0, r_np = 0, r_nupd = 0, r_fail = 0;
    bit               r_op = 1'b0, r_dir = 1'b0, r_err = 1'b0;
    logic [TAP_W-1:0] tap0 = '0, tap_m = TAP_W'(TAP_INIT);
    logic             dir_m = 1'b0;
    int               mv_cnt = 0, ld_cnt = 0, done_off = -1;
    logic             done_err_seen = 1'b0;
    int               t, upd, n, lim;
    logic             e_ready, e_move, e_load, e_done, e_dir;
    logic [TAP_W-1:0] e_tap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge FAB_CLK) cyc++;

    always @(negedge FAB_CLK) begin
        if (in_rst) begin
            busy  = 1'b0;
            oor   = 1'b0;
            tap_m = TAP_W'(TAP_INIT);
            dir_m = 1'b0;
        end else begin
            if (busy && (cyc - acc_cyc) > d_off) busy = 1'b0;
            t       = cyc - acc_cyc;
            e_ready = !busy;
            e_move  = 1'b0;
            e_load  = 1'b0;
            e_done  = 1'b0;
            e_tap   = tap_m;
            e_dir   = dir_m;
            if (busy) begin
                if (r_op) begin
                    e_load = (t >= 1) && (t <= LOAD_CYCLES);
                    e_tap  = (t >= LOAD_CYCLES + 1) ? TAP_W'(TAP_INIT) : tap0;
                end else begin
                    e_move = (t >= 2) && ((t - 2) % PER == 0) && ((t - 2) / PER < r_np);
                    upd    = (t < 2 + PER) ? 0 : (t - 2) / PER;
                    if (upd > r_nupd) upd = r_nupd;
                    e_tap  = r_dir ? tap0 + TAP_W'(upd) : tap0 - TAP_W'(upd);
                end
                e_done = (t == d_off);
            end
            check("req_ready", 32'(req_ready), 32'(e_ready));
            check("move", 32'(mv), 32'(e_move));
            check("load", 32'(ld), 32'(e_load));
            check("done", 32'(done), 32'(e_done));
            check("direction", 32'(dirn), 32'(e_dir));
            check("tap_count", 32'(tap_count), 32'(e_tap));
            if (e_done) check("done_err", 32'(done_err), 32'(r_err));

            if (busy) begin
                if (mv === 1'b1) mv_cnt++;
                if (ld === 1'b1) ld_cnt++;
                if (done === 1'b1) begin
                    done_off      = t;
                    done_err_seen = done_err;
                end
                // Emulate the IOD refusing pulse number r_fail.
                if (!r_op && e_move && ((t - 2) / PER == r_fail - 1)) oor = 1'b1;
                if (t == d_off) oor = 1'b0;
            end

            if (!busy && req_valid) begin
                busy          = 1'b1;
                acc_cyc       = cyc;
                acc_cnt++;
                r_op          = req_op;
                r_dir         = req_dir;
                r_fail        = req_fail;
                tap0          = tap_m;
                mv_cnt        = 0;
                ld_cnt        = 0;
                done_off      = -1;
                done_err_seen = 1'b0;
                if (r_op) begin
                    r_np   = 0;
                    r_nupd = 0;
                    r_err  = 1'b0;
                    d_off  = LOAD_CYCLES + 1;
                    tap_m  = TAP_W'(TAP_INIT);
                end else begin
                    n   = int'(req_taps);
                    lim = n;
`ifdef IOD_DLY_SW_CLAMP_EN
                    if (r_dir) begin
                        if (MAX_T - int'(tap0) < lim) lim = (MAX_T > int'(tap0)) ? MAX_T - int'(tap0) : 0;
                    end else begin
                        if (int'(tap0) < lim) lim = int'(tap0);
                    end
`endif
                    if (r_fail != 0 && r_fail <= lim) begin
                        r_np   = r_fail;
                        r_nupd = r_fail - 1;
                        r_err  = 1'b1;
                    end else begin
                        r_np   = lim;
                        r_nupd = lim;
                        r_err  = (lim < n);
                    end
                    d_off = 2 + r_np * PER;
                    tap_m = r_dir ? tap0 + TAP_W'(r_nupd) : tap0 - TAP_W'(r_nupd);
                    dir_m = r_dir;
                end
            end
        end
    end

    task automatic present(input logic op, input logic dir, input logic [TAP_W-1:0] taps, input int fail);
        int start;
        start = acc_cnt;
        @(posedge FAB_CLK); #1;
        req_valid = 1'b1;
        req_op    = op;
        req_dir   = dir;
        req_taps  = taps;
        req_fail  = fail;
        for (int i = 0; i < 400; i++) begin
            @(negedge FAB_CLK); #1;
            if (acc_cnt != start) break;
        end
        check("accepted", 32'(acc_cnt != start), 32'd1);
    endtask

    task automatic drop();
        @(posedge FAB_CLK); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            @(negedge FAB_CLK); #1;
            if (!busy) break;
        end
        check("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic check_req(input string tag, input int e_mv, input int e_doff,
                             input logic e_err, input int e_tp);
        check({tag, "_pulses"}, 32'(mv_cnt), 32'(e_mv));
        check({tag, "_done_cycle"}, 32'(done_off), 32'(e_doff));
        check({tag, "_done_err"}, 32'(done_err_seen), 32'(e_err));
        check({tag, "_tap"}, 32'(tap_count), 32'(e_tp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        logic op, dir;
        logic [TAP_W-1:0] taps;
        int fail;

        #23;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_done_err", 32'(done_err), 32'd0);
        check("rst_move", 32'(mv), 32'd0);
        check("rst_dir", 32'(dirn), 32'd0);
        check("rst_load", 32'(ld), 32'd0);
        check("rst_tap", 32'(tap_count), 32'd1);
        @(posedge FAB_CLK); #2;
        ARST_N = 1'b1;
        in_rst = 1'b0;

        present(1'b1, 1'b0, 8'd0, 0); drop(); wait_idle();
        check("load_cycles", 32'(ld_cnt), 32'd2);
        check_req("load", 0, 3, 1'b0, 1);

`ifdef IOD_DLY_SW_CLAMP_EN
        present(1'b0, 1'b1, 8'd5, 0); drop(); wait_idle();
        check_req("clamp_up5", 2, 10, 1'b1, 3);
        present(1'b0, 1'b0, 8'd0, 0); drop(); wait_idle();
        check_req("move0", 0, 2, 1'b0, 3);
        present(1'b0, 1'b0, 8'd5, 2); drop(); wait_idle();
        check_req("oor_down5", 2, 10, 1'b1, 2);
`else
        present(1'b0, 1'b1, 8'd4, 0); drop(); wait_idle();
        check_req("up4", 4, 18, 1'b0, 5);
        check("up4_dir", 32'(dirn), 32'd1);
        present(1'b0, 1'b0, 8'd0, 0); drop(); wait_idle();
        check_req("move0", 0, 2, 1'b0, 5);
        present(1'b0, 1'b0, 8'd5, 2); drop(); wait_idle();
        check_req("oor_down5", 2, 10, 1'b1, 4);
`endif

        // Reset in the GAP after the second pulse of an upward move.
        present(1'b1, 1'b0, 8'd0, 0); drop(); wait_idle();
        present(1'b0, 1'b1, 8'd4, 0);
        a = acc_cyc;
        drop();
        for (int i = 0; i < 50; i++) begin
            @(posedge FAB_CLK); #2;
            if (cyc - a >= 8) break;
        end
        in_rst = 1'b1;
        ARST_N = 1'b0;
        #1;
        check("midrst_move", 32'(mv), 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd1);
        check("midrst_tap", 32'(tap_count), 32'd1);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_dir", 32'(dirn), 32'd0);
        @(posedge FAB_CLK); #2;
        ARST_N = 1'b1;
        in_rst = 1'b0;
        present(1'b0, 1'b1, 8'd2, 0); drop(); wait_idle();
        check_req("post_rst_up2", 2, 10, 1'b0, 3);

        for (int k = 0; k < 40; k++) begin
            op   = ($urandom % 7 == 0);
            dir  = 1'($urandom % 2);
            taps = op ? TAP_W'($urandom % 256) : TAP_W'($urandom_range(0, 6));
            fail = (!op && taps != 0 && $urandom % 4 == 0) ? $urandom_range(1, int'(taps)) : 0;
            present(op, dir, taps, fail);
            if ($urandom % 3 != 0) begin
                drop();
                repeat ($urandom % 3) @(posedge FAB_CLK);
            end
        end
        drop();
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
